// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter family.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Index width for n sources; never below 1 bit so ports stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req scanning from last+1 upward, wrapping at n.
  // Sized for the widest legal configuration (16 sources); callers
  // zero-extend. Returns last unchanged when nothing is requesting.
  function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                         input logic [3:0]  last,
                                         input int          n);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = last;
    found = 1'b0;
    for (int off = 1; off <= 16; off++) begin
      if (off <= n && !found) begin
        idx = (int'(last) + off) % n;
        if (req[4'(idx)]) begin
          res   = 4'(idx);
          found = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_picker.sv
// Combinational round-robin selector; reusable by other schedulers.
module rr_priority_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]          req,
  input  logic [idx_w(NUM_SRC)-1:0]   last_grant,
  output logic [idx_w(NUM_SRC)-1:0]   pick,
  output logic                        any_req
);
  localparam int IW = idx_w(NUM_SRC);

  assign any_req = |req;
  assign pick    = IW'(rr_pick(16'(req), 4'(last_grant), NUM_SRC));

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI-Stream sources share one
// master port. A grant is held until the owner's tlast beat is accepted.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             axis_aclk,
  input  logic                             axis_areset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [NUM_SRC-1:0]               s_axis_tvalid,
  input  logic [NUM_SRC-1:0]               s_axis_tlast,
  output logic [NUM_SRC-1:0]               s_axis_tready,
  input  logic                             m01_axis_tready,
  output logic [DATA_WIDTH-1:0]            m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]          m01_axis_tstrb,
  output logic                             m01_axis_tvalid,
  output logic                             m01_axis_tlast,
  output logic [$clog2(NUM_SRC)-1:0]       grant_id,
  output logic                             busy,
  output logic [NUM_SRC*CNT_WIDTH-1:0]     pkt_count
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = idx_w(NUM_SRC);

  arb_state_t    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic          any_req;
  logic          pkt_end;

  rr_priority_picker #(.NUM_SRC(NUM_SRC)) u_pick (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .pick       (pick),
    .any_req    (any_req)
  );

  // Owner's tlast beat is accepted this cycle.
  assign pkt_end = (state == ARB_BUSY) && s_axis_tvalid[grant_id] &&
                   s_axis_tlast[grant_id] && m01_axis_tready;

  // Grant FSM: arbitrate in IDLE on live tvalid, release on packet end.
  // The IDLE cycle between packets is the arbitration slot.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state      <= ARB_IDLE;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= IW'(NUM_SRC - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (pkt_end) begin
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output mux from the registered grant; everything quiet outside BUSY.
  always_comb begin
    m01_axis_tdata  = '0;
    m01_axis_tstrb  = '0;
    m01_axis_tvalid = 1'b0;
    m01_axis_tlast  = 1'b0;
    s_axis_tready   = '0;
    if (state == ARB_BUSY) begin
      m01_axis_tdata          = s_axis_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
      m01_axis_tstrb          = s_axis_tstrb[grant_id*SW +: SW];
      m01_axis_tvalid         = s_axis_tvalid[grant_id];
      m01_axis_tlast          = s_axis_tlast[grant_id];
      s_axis_tready[grant_id] = m01_axis_tready;
    end
  end

  // Per-source saturating packet counters.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;

    // Count accepted tlast beats of source i, holding at all-ones.
    always_ff @(posedge axis_aclk) begin
      if (axis_areset)
        cnt <= '0;
      else if (pkt_end && grant_id == IW'(i) && cnt != '1)
        cnt <= cnt + 1'b1;
    end

    assign pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

endmodule
